// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and counter sizing for the multiword add sequencer
package alu_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    // One bit minimum, so that words=1 and words=2 both yield a legal counter
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: start/ready/done handshake and operand/result bus
// Optional SUBTRACT_EN adds the sub request bit.
interface multiword_add_sequencer_if #(parameter int size = 4, parameter int words = 4);
    logic                  start;
    logic [size*words-1:0] x;
    logic [size*words-1:0] y;
`ifdef SUBTRACT_EN
    logic                  sub;
`endif
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [size*words-1:0] s;
    logic                  cout;
    modport master (
`ifdef SUBTRACT_EN
        output sub,
`endif
        output start, x, y,
        input ready, busy, done, s, cout
    );
    modport slave (
`ifdef SUBTRACT_EN
        input sub,
`endif
        input start, x, y,
        output ready, busy, done, s, cout
    );
endinterface

// File: rtl/slice_adder_ci.sv
// slice_adder_ci: stateless size-bit ripple-carry adder with carry-in
module slice_adder_ci #(parameter int size = 4) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            ci,
    output logic [size-1:0] sum,
    output logic            co
);
    logic [size:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < size; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[size];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: wide add over `words` cycles through one shared size-bit slice
// Define SUBTRACT_EN to add the sub port (x - y, cout=1 means no borrow).
module multiword_add_sequencer import alu_seq_pkg::*; #(
    parameter int size  = 4,
    parameter int words = 4
) (
    input logic clk,
    input logic rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int w  = size * words;
    localparam int cw = cnt_w(words);
    state_t         state, state_nx;
    logic [w-1:0]   xr, yr, sr, yin;
    logic [cw-1:0]  count;
    logic [size-1:0] sum;
    logic           carry, cout_r, co, ci0, last, accept;
    slice_adder_ci #(.size(size)) u_slice (
        .a(xr[size-1:0]), .b(yr[size-1:0]), .ci(carry), .sum(sum), .co(co)
    );
`ifdef SUBTRACT_EN
    assign ci0 = bus.sub;
    assign yin = bus.sub ? ~bus.y : bus.y;
`else
    assign ci0 = 1'b0;
    assign yin = bus.y;
`endif
    assign last   = count == cw'(words - 1);
    assign accept = (state == IDLE) && bus.start;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        bus.ready = state == IDLE;
        bus.busy  = state == RUN;
        bus.done  = state == DONE;
        bus.s     = sr;
        bus.cout  = cout_r;
    end
    // Each slice sum enters at the top of s; after `words` shifts the LSB slice is at the bottom
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            xr <= '0; yr <= '0; sr <= '0; carry <= 1'b0; count <= '0; cout_r <= 1'b0;
        end else if (accept) begin
            xr <= bus.x; yr <= yin; carry <= ci0; count <= '0;
        end else if (state == RUN) begin
            xr    <= xr >> size;
            yr    <= yr >> size;
            sr    <= (sr >> size) | (w'(sum) << (w - size));
            carry <= co;
            count <= count + 1'b1;
            if (last) cout_r <= co;
        end
endmodule
